defog_core_param: RTL and testbench



---
 rtl/defog_core_param.sv | 229 ++++++++++++++++++++++
 tb/tb_defog_core_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/defog_core_param.sv
`default_nettype none
// ============================================================================
// Module : defog_core_param
// Dark-channel-prior defog pipeline, 6 stages, 1 pixel/clock. Defining
// DEFOG_AUTO_ATMOS_EN enables per-frame atmospheric light estimation.
// Rev    : 1.0
// ============================================================================
module defog_core_param #(
  parameter int DW    = 8,
  parameter int WIN   = 5,
  parameter int OMEGA = 243,
  parameter int T0    = 26,
  parameter int A_MIN = 16,
  parameter int A_FIX = (1 << DW) - 1
) (
  input  logic            pixelclk,
  input  logic            reset,
  input  logic [3*DW-1:0] i_rgb,
  input  logic            i_hsync,
  input  logic            i_vsync,
  input  logic            i_de,
  output logic [3*DW-1:0] o_rgb,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [DW-1:0]   o_atmos
);

  localparam int RW    = DW + 9;
  localparam int PW    = 2 * DW + 17;
  localparam int MW    = DW + 19;
  localparam int DDW   = DW + 11;
  localparam int SW    = DW + 12;
  localparam int HD    = (WIN > 1) ? WIN - 1 : 1;
  localparam int TPMAX = 256 - T0;
  localparam logic [DW-1:0] A_RST     = DW'((1 << DW) - 1);
  localparam logic [RW-1:0] RECIP_RST = RW'((1 << (DW + 8)) / ((1 << DW) - 1));

  logic [2:0]            ctl [1:6];
  logic [3*DW-1:0]       rgb1, rgb2, rgb3, rgb4;
  logic [DW-1:0]         dark2, a3, a4, a5;
  logic [RW-1:0]         p3;
  logic [16:0]           rt4;
  logic signed [DDW-1:0] d5 [3];
  logic [DW-1:0]         a_cur;
  logic [RW-1:0]         recip_cur;

  // S1 combinational: min of channels
  logic [DW-1:0] r1, g1, b1, rg_min, m1;
  assign r1     = rgb1[3*DW-1:2*DW];
  assign g1     = rgb1[2*DW-1:DW];
  assign b1     = rgb1[DW-1:0];
  assign rg_min = (r1 < g1) ? r1 : g1;
  assign m1     = (rg_min < b1) ? rg_min : b1;

  // Causal window: the current m plus up to WIN-1 earlier m of the same run
  logic [DW-1:0] hist [HD];
  logic [HD-1:0] hist_v;
  logic [DW-1:0] dark_c;

  always_comb begin
    dark_c = m1;
    for (int i = 0; i < HD; i++) begin
      if (WIN > 1 && hist_v[i] && hist[i] < dark_c) dark_c = hist[i];
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      hist_v <= '0;
    end else if (!ctl[1][0]) begin
      hist_v <= '0;
    end else begin
      hist[0]   <= m1;
      hist_v[0] <= 1'b1;
      for (int i = 1; i < HD; i++) begin
        hist[i]   <= hist[i-1];
        hist_v[i] <= hist_v[i-1];
      end
    end
  end

  // S3: haze estimate p
  logic [PW-1:0] prod3;
  logic [RW-1:0] p_c;
  assign prod3 = PW'(OMEGA) * PW'(dark2) * PW'(recip_cur);
  assign p_c   = RW'(prod3 >> (DW + 8));

  // S4: transmission with floor, then reciprocal ROM
  logic [8:0]  t_c;
  logic [16:0] rt_rom [0:256];
  assign t_c = (p3 > RW'(TPMAX)) ? 9'(T0) : 9'd256 - p3[8:0];

  for (genvar g = 0; g <= 256; g++) begin : g_rt_rom
    assign rt_rom[g] = 17'(65536 / ((g == 0) ? 1 : g));
  end

  // S5/S6 per channel: signed radiance correction and clamp
  logic signed [DDW-1:0] d_c [3];
  logic [DW-1:0]         j_c [3];

  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic signed [DW:0]    diff;
    logic signed [MW-1:0]  prod;
    logic signed [SW-1:0]  sum;
    assign diff   = $signed({1'b0, rgb4[c*DW +: DW]}) - $signed({1'b0, a4});
    assign prod   = MW'(diff) * MW'($signed({1'b0, rt4}));
    assign d_c[c] = DDW'(prod >>> 8);
    assign sum    = SW'($signed({1'b0, a5})) + SW'(d5[c]);
    assign j_c[c] = sum[SW-1] ? '0 : ((|sum[SW-2:DW]) ? {DW{1'b1}} : sum[DW-1:0]);
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      for (int k = 1; k <= 6; k++) ctl[k] <= '0;
      rgb1  <= '0;
      rgb2  <= '0;
      rgb3  <= '0;
      rgb4  <= '0;
      dark2 <= '0;
      p3    <= '0;
      rt4   <= '0;
      a3    <= '0;
      a4    <= '0;
      a5    <= '0;
      for (int c = 0; c < 3; c++) d5[c] <= '0;
      o_rgb <= '0;
    end else begin
      ctl[1] <= {i_hsync, i_vsync, i_de};
      for (int k = 2; k <= 6; k++) ctl[k] <= ctl[k-1];
      rgb1  <= i_rgb;
      rgb2  <= rgb1;
      rgb3  <= rgb2;
      rgb4  <= rgb3;
      dark2 <= dark_c;
      // A travels with the pixel from S3 so one pixel never mixes two frames' pairs
      p3    <= p_c;
      a3    <= a_cur;
      rt4   <= rt_rom[t_c];
      a4    <= a3;
      a5    <= a4;
      for (int c = 0; c < 3; c++) begin
        d5[c]              <= d_c[c];
        o_rgb[c*DW +: DW]  <= j_c[c];
      end
    end
  end

  assign {o_hsync, o_vsync, o_de} = ctl[6];

`ifdef DEFOG_AUTO_ATMOS_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  localparam int CW = $clog2(RW + 1);

  state_t        state, state_nx;
  logic          frame_start;
  logic [DW-1:0] fmax, a_next, rem, rem_nx;
  logic [DW:0]   rem_sh;
  logic          q_bit;
  logic [RW-1:0] quo;
  logic [CW-1:0] cnt;

  assign frame_start = i_vsync & ~ctl[1][1];

  // Dividend 2^(DW+8): only its first (MSB) bit is one
  assign rem_sh = {rem, (cnt == '0)};
  assign q_bit  = (rem_sh >= {1'b0, a_next});
  assign rem_nx = q_bit ? DW'(rem_sh - {1'b0, a_next}) : DW'(rem_sh);

  always_ff @(posedge pixelclk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: state_nx = ST_IDLE;
      ST_DIV:  if (cnt == CW'(RW - 1)) state_nx = ST_LOAD;
      ST_LOAD: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (frame_start) state_nx = ST_DIV;
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      fmax      <= '0;
      a_next    <= A_RST;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      a_cur     <= A_RST;
      recip_cur <= RECIP_RST;
    end else begin
      if (frame_start) begin
        a_next <= (fmax < DW'(A_MIN)) ? DW'(A_MIN) : fmax;
        fmax   <= '0;
        rem    <= '0;
        quo    <= '0;
        cnt    <= '0;
      end else begin
        if (ctl[2][0] && dark2 > fmax) fmax <= dark2;
        if (state == ST_DIV) begin
          rem <= rem_nx;
          quo <= {quo[RW-2:0], q_bit};
          cnt <= cnt + 1'b1;
        end
      end
      if (state == ST_LOAD) begin
        a_cur     <= a_next;
        recip_cur <= quo;
      end
    end
  end
`else
  assign a_cur     = DW'(A_FIX);
  assign recip_cur = RW'((1 << (DW + 8)) / A_FIX);
`endif

  assign o_atmos = a_cur;

endmodule
`default_nettype wire

// File: tb/tb_defog_core_param.sv
`default_nettype none
// ============================================================================
// Module : tb_defog_core_param
// Randomized scoreboard bench for defog_core_param against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_defog_core_param;

  localparam int DW    = 8;
  localparam int WIN   = 5;
  localparam int OMEGA = 243;
  localparam int T0    = 26;
  localparam int A_MIN = 16;
  localparam int A_FIX = (1 << DW) - 1;
  localparam int PXW   = 3 * DW;
  localparam int HIST  = 16384;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [PXW-1:0] i_rgb = '0;
  logic           i_hsync = 1'b0;
  logic           i_vsync = 1'b0;
  logic           i_de = 1'b0;
  logic [PXW-1:0] o_rgb;
  logic           o_hsync, o_vsync, o_de;
  logic [DW-1:0]  o_atmos;

  defog_core_param #(
    .DW(DW), .WIN(WIN), .OMEGA(OMEGA), .T0(T0), .A_MIN(A_MIN), .A_FIX(A_FIX)
  ) dut (
    .pixelclk(clk), .reset(reset), .i_rgb(i_rgb), .i_hsync(i_hsync),
    .i_vsync(i_vsync), .i_de(i_de), .o_rgb(o_rgb), .o_hsync(o_hsync),
    .o_vsync(o_vsync), .o_de(o_de), .o_atmos(o_atmos)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PXW-1:0] rgb;
    int             cyc;
  } exp_t;

  int       cyc = 0;
  int       checks = 0;
  int       failures = 0;
  int       last_rst = 0;
  int       a_model = A_FIX;
  int       fmax_m = 0;
  int       win_q[$];
  exp_t     sb_q[$];
  logic [2:0] ctl_hist [0:HIST-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: recovered pixel from the defog equations
  function automatic logic [PXW-1:0] recover(input logic [PXW-1:0] px, input int dark, input int a);
    longint p, x, q;
    int t, rt, j, ic;
    logic [PXW-1:0] r;
    r = '0;
    p = (longint'(OMEGA) * longint'(dark) * longint'((1 << (DW + 8)) / a)) / (longint'(1) << (DW + 8));
    t = (p >= longint'(256 - T0)) ? T0 : 256 - int'(p);
    rt = 65536 / t;
    for (int c = 0; c < 3; c++) begin
      ic = int'(px[c*DW +: DW]);
      x = longint'(ic - a) * longint'(rt);
      q = (x >= 0) ? x / 256 : -((-x + 255) / 256);
      j = a + int'(q);
      if (j < 0) j = 0;
      if (j > (1 << DW) - 1) j = (1 << DW) - 1;
      r[c*DW +: DW] = DW'(j);
    end
    return r;
  endfunction

  function automatic int next_a();
`ifdef DEFOG_AUTO_ATMOS_EN
    return (fmax_m < A_MIN) ? A_MIN : fmax_m;
`else
    return A_FIX;
`endif
  endfunction

  function automatic int exp_fix(input int v);
`ifdef DEFOG_AUTO_ATMOS_EN
    return v;
`else
    return (v < 0) ? A_FIX : A_FIX;
`endif
  endfunction

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic step(input logic [PXW-1:0] rgb, input logic de, input logic hs,
                      input logic vs, input logic rs);
    @(negedge clk);
    i_rgb = rgb; i_de = de; i_hsync = hs; i_vsync = vs; reset = rs;
    if (cyc < HIST) ctl_hist[cyc] = {hs, vs, de};
    if (rs) last_rst = cyc;
    if (!de) win_q.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pixel(input logic [PXW-1:0] rgb, input logic hs,
                       input bit use_exp, input logic [PXW-1:0] exp_rgb);
    int m, dark;
    exp_t e;
    step(rgb, 1'b1, hs, 1'b0, 1'b0);
    m = int'(rgb[DW-1:0]);
    for (int c = 1; c < 3; c++) if (int'(rgb[c*DW +: DW]) < m) m = int'(rgb[c*DW +: DW]);
    win_q.push_back(m);
    if (win_q.size() > WIN) void'(win_q.pop_front());
    dark = m;
    foreach (win_q[k]) if (win_q[k] < dark) dark = win_q[k];
    if (dark > fmax_m) fmax_m = dark;
    e.rgb = use_exp ? exp_rgb : recover(rgb, dark, a_model);
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  task automatic frame_boundary(input int exp_a);
    int c0, old_a;
    idle(4);
    old_a = a_model;
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    for (int k = 1; k <= 22; k++) begin
      step('0, 1'b0, 1'b0, (k < 3), 1'b0);
      if (cyc == c0 + DW + 10) check_val("atmos_hold", int'(o_atmos), old_a);
      if (cyc == c0 + DW + 11) check_val("atmos_update", int'(o_atmos), exp_a);
    end
    a_model = exp_a;
    fmax_m = 0;
  endtask

  task automatic rand_frame(input int lines);
    int n;
    logic hs;
    for (int l = 0; l < lines; l++) begin
      n = $urandom_range(8, 24);
      hs = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) step('0, 1'b0, hs, 1'b0, 1'b0);
        pixel(PXW'($urandom), hs, 1'b0, '0);
      end
      idle($urandom_range(1, 3));
    end
  endtask

  // Monitor: control delay and scoreboard pops on every output pixel
  always @(negedge clk) begin
    exp_t e;
    if (cyc >= 6 && (cyc - 6) > last_rst && (cyc - 6) < HIST) begin
      checks++;
      if ({o_hsync, o_vsync, o_de} !== ctl_hist[cyc-6]) begin
        failures++;
        $display("FAIL ctl_delay: got %b expected %b (cycle %0d)",
                 {o_hsync, o_vsync, o_de}, ctl_hist[cyc-6], cyc);
      end
    end
    if (o_de === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL pixel_unexpected: got %h expected no output (cycle %0d)", o_rgb, cyc);
      end else begin
        e = sb_q.pop_front();
        if (o_rgb !== e.rgb || cyc != e.cyc + 6) begin
          failures++;
          $display("FAIL pixel_out: got %h at cycle %0d expected %h at cycle %0d",
                   o_rgb, cyc, e.rgb, e.cyc + 6);
        end
      end
    end
  end

  initial begin
    int c0;
    for (int k = 0; k < HIST; k++) ctl_hist[k] = '0;

    repeat (3) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("reset_rgb", int'(o_rgb), 0);
    check_val("reset_de", int'(o_de), 0);
    check_val("reset_atmos", int'(o_atmos), 255);
    idle(3);

    pixel({8'd200, 8'd0, 8'd100}, 1'b1, 1'b1, {8'd200, 8'd0, 8'd100});
    idle(2);
    pixel({8'd200, 8'd200, 8'd200}, 1'b1, 1'b1, {8'd41, 8'd41, 8'd41});
    idle(2);

    // Window sequence m = 50,40,60,70,80,90,100 then a fresh line starting at 90
    foreach (win_q[k]) win_q[k] = win_q[k];
    begin
      int mseq[7] = '{50, 40, 60, 70, 80, 90, 100};
      for (int i = 0; i < 7; i++)
        pixel({DW'(mseq[i]), DW'(mseq[i] + 10), DW'(mseq[i] + 20)}, 1'b1, 1'b0, '0);
    end
    idle(2);
    pixel({8'd90, 8'd95, 8'd99}, 1'b1, 1'b0, '0);
    frame_boundary(next_a());

    rand_frame(4);
    frame_boundary(next_a());
    rand_frame(4);
    frame_boundary(next_a());

    pixel({8'd120, 8'd130, 8'd140}, 1'b0, 1'b0, '0);
    pixel({8'd60, 8'd70, 8'd80}, 1'b0, 1'b0, '0);
    frame_boundary(exp_fix(120));

    pixel({8'd5, 8'd9, 8'd200}, 1'b0, 1'b0, '0);
    pixel({8'd3, 8'd200, 8'd200}, 1'b0, 1'b0, '0);
    frame_boundary(exp_fix(16));

    // Reset lands mid-division: the pending A must be abandoned
    idle(4);
    step('0, 1'b0, 1'b0, 1'b1, 1'b0);
    c0 = cyc;
    for (int k = 1; k <= 30; k++) begin
      step('0, 1'b0, 1'b0, (k < 3), (k == 5 || k == 6));
      if (cyc == c0 + DW + 11) check_val("atmos_after_reset", int'(o_atmos), 255);
    end
    check_val("atmos_reset_settled", int'(o_atmos), 255);
    a_model = A_FIX;
    fmax_m = 0;
    frame_boundary(exp_fix(16));

    rand_frame(3);
    idle(12);
    check_val("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
